acceptance_filter_ctrl: RTL and testbench
=========================================

# acceptance_filter_ctrl

Host-side configuration controller for the acceptance filter. It owns the AFR, AFMR1-4 and AFIR1-4 register bank and drives the filter's mask, ID and enable inputs. It enforces the write-protection rule: a mask or ID pair is writable only while its filter is disabled. It sequences enable changes into the filter only while the filter datapath is quiescent, and reports this through o_acfbsy.

## Interface
- SYNC_TIMEOUT, 255: maximum number of SYNC_WAIT cycles before an enable change is forced (valid range 2..65535).

Ports:
- i_sys_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_reg_wr  in  1  one-cycle write strobe. The host issues at most one request per o_reg_ack.
- i_reg_rd  in  1  one-cycle read strobe.
- i_reg_addr  in  4  word address of the register.
- i_reg_wdata  in  32  write data.
- o_reg_rdata  out  32  read data, valid while o_reg_ack=1.
- o_reg_ack  out  1  one-cycle completion pulse.
- o_reg_err  out  1  error flag, qualified by o_reg_ack.
- i_filter_busy  in  1  high while the filter FSM is outside IDLE.
- o_afmr1..o_afmr4  out  32 each  active mask registers.
- o_afir1..o_afir4  out  32 each  active ID registers.
- o_uaf1..o_uaf4  out  1 each  active filter enables.
- o_acfbsy  out  1  high while an enable change is pending.

## Operation
- Address map:
  - 0: AFR. Bits[3:0] are UAF4..UAF1. Upper bits are ignored on write and read as 0.
  - 1-4: AFMR1-4.
  - 5-8: AFIR1-4.
  - 9: STATUS. Bit0 is o_acfbsy (read-only). Bit1 is a sticky timeout flag; writing 1 to bit1 clears it.
  - 10-15: invalid.
- Enable registers:
  - uaf_shadow[3:0] holds the host-written AFR value. AFR reads return uaf_shadow.
  - uaf_active[3:0] drives o_uaf1..o_uaf4.
- Request handling: requests are serviced in every state.
  - A request sampled at edge N produces o_reg_ack=1 for exactly one cycle after edge N.
  - All register updates for that request occur at edge N.
- Error cases. Each sets o_reg_err=1 with ack, makes no register change and returns o_reg_rdata=0:
  - i_reg_wr and i_reg_rd both high in the same cycle.
  - Invalid address.
  - AFMRn or AFIRn write while uaf_shadow[n]=1 or uaf_active[n]=1.
  - AFR write while the state is not IDLE.
- A successful AFMRn or AFIRn write updates o_afmrn or o_afirn at edge N.
- AFR write in IDLE:
  - uaf_shadow is loaded at edge N.
  - If the new value differs from uaf_active, then at edge N: o_acfbsy=1, state goes to SYNC_WAIT, idle_cnt=0, timer=0.
  - If the new value equals uaf_active, there is no state change.
- State machine (IDLE, SYNC_WAIT, APPLY):
  - SYNC_WAIT, each edge:
    - timer increments.
    - If i_filter_busy=1, idle_cnt is cleared.
    - If i_filter_busy=0 and idle_cnt=0, idle_cnt is set to 1.
    - If i_filter_busy=0 and idle_cnt=1 (second consecutive quiet cycle), go to APPLY.
    - Else if timer=SYNC_TIMEOUT-1, go to APPLY and set STATUS bit1.
  - APPLY, one edge: uaf_active<=uaf_shadow, o_acfbsy<=0, go to IDLE.
- Reset values: every output is 0, all registers, shadow and active enables are 0, the timeout flag is 0, and the state is IDLE. With all enables at 0, the filter accepts every message.
- Reset asserted mid-SYNC_WAIT aborts the change. No partial enable update is applied.

## Timing
- Read and write latency is 1 cycle from strobe to ack. Back-to-back requests are allowed on alternate cycles.
- Minimum enable-change sequence with i_filter_busy=0:
  - Edge N: write sampled, o_acfbsy=1.
  - Edge N+1: idle_cnt=1.
  - Edge N+2: state goes to APPLY.
  - Edge N+3: o_uafn updated and o_acfbsy=0.
  - o_acfbsy is high for exactly 3 cycles.
- Worst case with the filter continuously busy: SYNC_TIMEOUT+1 cycles from the write to the enable update.
- Mask and ID outputs change only at a successful write edge. Because of the write-protection rule, they never change while the corresponding uaf_active bit is 1.
- STATUS bit1 clear and a simultaneous timeout set in the same edge: set wins.

## Test plan
- Reset check: assert reset and release it. All outputs are 0, and reading addresses 0, 1 and 9 returns 0 with err=0.
- Mask and ID write path, UAF1=0:
  - Write AFMR1=0xFFE00000 and AFIR1=0x12300000. Each gets ack with err=0.
  - o_afmr1 and o_afir1 carry the new values one cycle later.
  - Read-back matches.
- Enable sequencing, i_filter_busy=0:
  - Write AFR=0x1. o_acfbsy is high for 3 cycles, then o_uaf1=1.
  - Then write AFMR1=0. This gets err=1 and o_afmr1 stays 0xFFE00000.
- Quiescence wait and timeout, SYNC_TIMEOUT=16:
  - Hold i_filter_busy=1 and write AFR=0x3. After 16 SYNC_WAIT cycles, o_uaf1=o_uaf2=1 and STATUS reads 0x2.
  - Write 0x2 to STATUS. STATUS then reads 0.
- Busy-pulse restart: with busy pattern 0,1,0,0 after the AFR write, the apply happens only after the final two quiet cycles. Timer and idle_cnt must not be confused by the interruption.
- Error paths:
  - AFR write during SYNC_WAIT returns err=1 and uaf_shadow is unchanged.
  - Read of address 12 returns err=1 with rdata=0.
  - Simultaneous rd and wr returns err=1 with no update.
  - Reset mid-SYNC_WAIT leaves o_uaf=0 and o_acfbsy=0.

Source files
------------

// File: rtl/acceptance_filter_ctrl.sv
// Acceptance filter configuration controller: AFR/AFMR/AFIR register bank and filter enable sequencing.
// Latency: every register request is acknowledged one cycle after its strobe; enable changes take at least 3 cycles.
// Backpressure: none on the host port; enable changes wait for two quiet filter cycles or SYNC_TIMEOUT cycles.
//
// Ports:
//   i_sys_clk, i_reset          clock, async active-high reset
//   i_reg_wr/rd/addr/wdata      host request (one request per o_reg_ack)
//   o_reg_rdata/ack/err         host response, valid with o_reg_ack
//   i_filter_busy               filter datapath not idle
//   o_afmr1..4, o_afir1..4      active mask / ID registers
//   o_uaf1..4                   active filter enables
//   o_acfbsy                    enable change in progress
module acceptance_filter_ctrl #(
  parameter int unsigned SYNC_TIMEOUT = 255
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic        i_reg_wr,
  input  logic        i_reg_rd,
  input  logic [3:0]  i_reg_addr,
  input  logic [31:0] i_reg_wdata,
  output logic [31:0] o_reg_rdata,
  output logic        o_reg_ack,
  output logic        o_reg_err,
  input  logic        i_filter_busy,
  output logic [31:0] o_afmr1,
  output logic [31:0] o_afmr2,
  output logic [31:0] o_afmr3,
  output logic [31:0] o_afmr4,
  output logic [31:0] o_afir1,
  output logic [31:0] o_afir2,
  output logic [31:0] o_afir3,
  output logic [31:0] o_afir4,
  output logic        o_uaf1,
  output logic        o_uaf2,
  output logic        o_uaf3,
  output logic        o_uaf4,
  output logic        o_acfbsy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SYNC_WAIT = 2'd1,
    ST_APPLY     = 2'd2
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(SYNC_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] afmr_q [4];
  logic [31:0] afmr_d [4];
  logic [31:0] afir_q [4];
  logic [31:0] afir_d [4];
  logic [3:0]  uaf_shadow_q, uaf_shadow_d;
  logic [3:0]  uaf_active_q, uaf_active_d;
  logic        tmo_q, tmo_d;
  logic        acfbsy_q, acfbsy_d;
  logic        idle_cnt_q, idle_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  sel;

  // Addresses 1..4 and 5..8 both map to index (addr-1) mod 4.
  assign sel = i_reg_addr[1:0] - 2'd1;

  always_comb begin
    state_d      = state_q;
    afmr_d       = afmr_q;
    afir_d       = afir_q;
    uaf_shadow_d = uaf_shadow_q;
    uaf_active_d = uaf_active_q;
    tmo_d        = tmo_q;
    acfbsy_d     = acfbsy_q;
    idle_cnt_d   = idle_cnt_q;
    timer_d      = timer_q;
    ack_d        = i_reg_wr | i_reg_rd;
    err_d        = 1'b0;
    rdata_d      = '0;

    // Host request: decoded against pre-edge state.
    if (i_reg_wr || i_reg_rd) begin
      if (i_reg_wr && i_reg_rd) begin
        err_d = 1'b1;
      end else if (i_reg_addr > 4'd9) begin
        err_d = 1'b1;
      end else if (i_reg_wr) begin
        if (i_reg_addr == 4'd0) begin
          if (state_q != ST_IDLE) begin
            err_d = 1'b1;
          end else begin
            uaf_shadow_d = i_reg_wdata[3:0];
            if (i_reg_wdata[3:0] != uaf_active_q) begin
              acfbsy_d   = 1'b1;
              state_d    = ST_SYNC_WAIT;
              idle_cnt_d = 1'b0;
              timer_d    = '0;
            end
          end
        end else if (i_reg_addr <= 4'd8) begin
          // Mask/ID pair is locked while its filter is requested or running.
          if (uaf_shadow_q[sel] || uaf_active_q[sel]) begin
            err_d = 1'b1;
          end else if (i_reg_addr <= 4'd4) begin
            afmr_d[sel] = i_reg_wdata;
          end else begin
            afir_d[sel] = i_reg_wdata;
          end
        end else if (i_reg_wdata[1]) begin
          tmo_d = 1'b0;
        end
      end else begin
        if (i_reg_addr == 4'd0) begin
          rdata_d = {28'd0, uaf_shadow_q};
        end else if (i_reg_addr <= 4'd4) begin
          rdata_d = afmr_q[sel];
        end else if (i_reg_addr <= 4'd8) begin
          rdata_d = afir_q[sel];
        end else begin
          rdata_d = {30'd0, tmo_q, acfbsy_q};
        end
      end
    end

    // Enable sequencing. Evaluated after the request so a timeout set beats a clear.
    case (state_q)
      ST_SYNC_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (i_filter_busy) begin
          idle_cnt_d = 1'b0;
        end else if (!idle_cnt_q) begin
          idle_cnt_d = 1'b1;
        end
        if (!i_filter_busy && idle_cnt_q) begin
          state_d = ST_APPLY;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_APPLY;
          tmo_d   = 1'b1;
        end
      end
      ST_APPLY: begin
        uaf_active_d = uaf_shadow_q;
        acfbsy_d     = 1'b0;
        state_d      = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        afmr_q[i] <= '0;
        afir_q[i] <= '0;
      end
      uaf_shadow_q <= '0;
      uaf_active_q <= '0;
      tmo_q        <= 1'b0;
      acfbsy_q     <= 1'b0;
      idle_cnt_q   <= 1'b0;
      timer_q      <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      afmr_q       <= afmr_d;
      afir_q       <= afir_d;
      uaf_shadow_q <= uaf_shadow_d;
      uaf_active_q <= uaf_active_d;
      tmo_q        <= tmo_d;
      acfbsy_q     <= acfbsy_d;
      idle_cnt_q   <= idle_cnt_d;
      timer_q      <= timer_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_reg_rdata = rdata_q;
  assign o_reg_ack   = ack_q;
  assign o_reg_err   = err_q;
  assign o_afmr1     = afmr_q[0];
  assign o_afmr2     = afmr_q[1];
  assign o_afmr3     = afmr_q[2];
  assign o_afmr4     = afmr_q[3];
  assign o_afir1     = afir_q[0];
  assign o_afir2     = afir_q[1];
  assign o_afir3     = afir_q[2];
  assign o_afir4     = afir_q[3];
  assign o_uaf1      = uaf_active_q[0];
  assign o_uaf2      = uaf_active_q[1];
  assign o_uaf3      = uaf_active_q[2];
  assign o_uaf4      = uaf_active_q[3];
  assign o_acfbsy    = acfbsy_q;

endmodule

// File: tb/tb_acceptance_filter_ctrl.sv
// Bench for acceptance_filter_ctrl: directed register/enable scenarios followed by random traffic.
// Every edge is mirrored by a transaction-level model; all outputs are compared on the falling edge.
// The filter busy input is the only backpressure source and is driven per cycle.
module tb_acceptance_filter_ctrl;

  localparam int TO = 16;

  logic        i_sys_clk = 1'b0;
  logic        i_reset;
  logic        i_reg_wr;
  logic        i_reg_rd;
  logic [3:0]  i_reg_addr;
  logic [31:0] i_reg_wdata;
  logic [31:0] o_reg_rdata;
  logic        o_reg_ack;
  logic        o_reg_err;
  logic        i_filter_busy;
  logic [31:0] dut_afmr [4];
  logic [31:0] dut_afir [4];
  logic [3:0]  dut_uaf;
  logic        o_acfbsy;

  always #5 i_sys_clk = ~i_sys_clk;

  acceptance_filter_ctrl #(.SYNC_TIMEOUT(TO)) dut (
    .i_sys_clk     (i_sys_clk),
    .i_reset       (i_reset),
    .i_reg_wr      (i_reg_wr),
    .i_reg_rd      (i_reg_rd),
    .i_reg_addr    (i_reg_addr),
    .i_reg_wdata   (i_reg_wdata),
    .o_reg_rdata   (o_reg_rdata),
    .o_reg_ack     (o_reg_ack),
    .o_reg_err     (o_reg_err),
    .i_filter_busy (i_filter_busy),
    .o_afmr1       (dut_afmr[0]),
    .o_afmr2       (dut_afmr[1]),
    .o_afmr3       (dut_afmr[2]),
    .o_afmr4       (dut_afmr[3]),
    .o_afir1       (dut_afir[0]),
    .o_afir2       (dut_afir[1]),
    .o_afir3       (dut_afir[2]),
    .o_afir4       (dut_afir[3]),
    .o_uaf1        (dut_uaf[0]),
    .o_uaf2        (dut_uaf[1]),
    .o_uaf3        (dut_uaf[2]),
    .o_uaf4        (dut_uaf[3]),
    .o_acfbsy      (o_acfbsy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents plus a pending-change record. The enable
  // change is decided from the recorded busy history since the AFR write.
  logic [31:0] m_afmr [4];
  logic [31:0] m_afir [4];
  logic [3:0]  m_shadow, m_active;
  bit          m_flag, m_pending, m_applying;
  bit          hist[$];
  logic        m_ack, m_err;
  logic [31:0] m_rdata;
  logic        last_err;
  logic [31:0] last_rdata;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_afmr[i] = '0;
      m_afir[i] = '0;
    end
    m_shadow = '0; m_active = '0;
    m_flag = 0; m_pending = 0; m_applying = 0;
    hist.delete();
    m_ack = 0; m_err = 0; m_rdata = '0;
  endtask

  task automatic model_edge();
    bit was_pending  = m_pending;
    bit was_applying = m_applying;
    int a = int'(i_reg_addr);
    int n;
    m_ack = i_reg_wr | i_reg_rd;
    m_err = 0;
    m_rdata = '0;
    if (i_reg_wr || i_reg_rd) begin
      if (i_reg_wr && i_reg_rd) m_err = 1;
      else if (a >= 10) m_err = 1;
      else if (i_reg_wr) begin
        if (a == 0) begin
          if (was_pending || was_applying) m_err = 1;
          else begin
            m_shadow = i_reg_wdata[3:0];
            if (m_shadow != m_active) begin
              m_pending = 1;
              hist.delete();
            end
          end
        end else if (a <= 8) begin
          n = (a - 1) % 4;
          if (m_shadow[n] || m_active[n]) m_err = 1;
          else if (a <= 4) m_afmr[n] = i_reg_wdata;
          else m_afir[n] = i_reg_wdata;
        end else if (i_reg_wdata[1]) m_flag = 0;
      end else begin
        if (a == 0) m_rdata = {28'd0, m_shadow};
        else if (a <= 4) m_rdata = m_afmr[(a - 1) % 4];
        else if (a <= 8) m_rdata = m_afir[(a - 1) % 4];
        else m_rdata = {30'd0, m_flag, (was_pending | was_applying)};
      end
    end
    if (was_applying) begin
      m_active   = m_shadow;
      m_applying = 0;
    end else if (was_pending) begin
      hist.push_back(i_filter_busy);
      n = hist.size();
      if (n >= 2 && !hist[n-1] && !hist[n-2]) begin
        m_pending = 0; m_applying = 1;
      end else if (n == TO) begin
        m_pending = 0; m_applying = 1; m_flag = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("ack", {31'd0, o_reg_ack}, {31'd0, m_ack});
    if (m_ack) begin
      check_eq("err", {31'd0, o_reg_err}, {31'd0, m_err});
      check_eq("rdata", o_reg_rdata, m_rdata);
    end
    check_eq("uaf", {28'd0, dut_uaf}, {28'd0, m_active});
    check_eq("acfbsy", {31'd0, o_acfbsy}, {31'd0, (m_pending | m_applying)});
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("afmr%0d", i + 1), dut_afmr[i], m_afmr[i]);
      check_eq($sformatf("afir%0d", i + 1), dut_afir[i], m_afir[i]);
    end
    last_err   = o_reg_err;
    last_rdata = o_reg_rdata;
  endtask

  // One clock: inputs already driven; model and compare on the falling edge, then drop strobes.
  task automatic tick();
    @(posedge i_sys_clk);
    @(negedge i_sys_clk);
    model_edge();
    check_outputs();
    i_reg_wr = 0;
    i_reg_rd = 0;
  endtask

  // Request then one gap cycle; response is captured in last_err/last_rdata after the first tick.
  task automatic do_req(input logic wr, input logic rd, input logic [3:0] addr, input logic [31:0] data);
    logic        e;
    logic [31:0] r;
    i_reg_wr = wr; i_reg_rd = rd; i_reg_addr = addr; i_reg_wdata = data;
    tick();
    e = last_err; r = last_rdata;
    tick();
    last_err = e; last_rdata = r;
  endtask

  task automatic apply_reset();
    i_reset = 1;
    #2;
    model_reset();
    check_outputs();
    @(negedge i_sys_clk);
    i_reset = 0;
  endtask

  int cnt;

  initial begin
    i_reset = 1; i_reg_wr = 0; i_reg_rd = 0; i_reg_addr = '0; i_reg_wdata = '0; i_filter_busy = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge i_sys_clk);
    i_reset = 0;

    // Reset read-back
    do_req(0, 1, 4'd0, '0); check_eq("rst_rd0", last_rdata, 32'h0); check_eq("rst_err0", {31'd0, last_err}, 32'h0);
    do_req(0, 1, 4'd1, '0); check_eq("rst_rd1", last_rdata, 32'h0);
    do_req(0, 1, 4'd9, '0); check_eq("rst_rd9", last_rdata, 32'h0); check_eq("rst_err9", {31'd0, last_err}, 32'h0);

    // Mask / ID write path with UAF1 off
    do_req(1, 0, 4'd1, 32'hFFE00000); check_eq("afmr1_werr", {31'd0, last_err}, 32'h0);
    do_req(1, 0, 4'd5, 32'h12300000); check_eq("afir1_werr", {31'd0, last_err}, 32'h0);
    check_eq("afmr1_out", dut_afmr[0], 32'hFFE00000);
    check_eq("afir1_out", dut_afir[0], 32'h12300000);
    do_req(0, 1, 4'd1, '0); check_eq("afmr1_rb", last_rdata, 32'hFFE00000);
    do_req(0, 1, 4'd5, '0); check_eq("afir1_rb", last_rdata, 32'h12300000);

    // Minimum enable sequence with a quiet filter
    i_filter_busy = 0;
    i_reg_wr = 1; i_reg_addr = 4'd0; i_reg_wdata = 32'h1;
    tick();
    cnt = int'(o_acfbsy);
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(o_acfbsy);
    end
    check_eq("acfbsy_cycles", cnt, 3);
    check_eq("uaf1_on", {31'd0, dut_uaf[0]}, 32'h1);
    do_req(1, 0, 4'd1, 32'h0); check_eq("afmr1_locked_err", {31'd0, last_err}, 32'h1);
    check_eq("afmr1_locked", dut_afmr[0], 32'hFFE00000);

    // Timeout with the filter held busy; AFR write during the wait is rejected
    i_filter_busy = 1;
    do_req(1, 0, 4'd0, 32'h3);
    do_req(1, 0, 4'd0, 32'hF); check_eq("afr_busy_err", {31'd0, last_err}, 32'h1);
    do_req(0, 1, 4'd0, '0);    check_eq("afr_shadow", last_rdata, 32'h3);
    for (int i = 0; i < 14; i++) tick();
    check_eq("uaf_after_tmo", {28'd0, dut_uaf}, 32'h3);
    do_req(0, 1, 4'd9, '0); check_eq("status_tmo", last_rdata, 32'h2);
    do_req(1, 0, 4'd9, 32'h2);
    do_req(0, 1, 4'd9, '0); check_eq("status_clr", last_rdata, 32'h0);

    // Busy pulse 0,1,0,0 after the write: apply only after the final quiet pair
    i_filter_busy = 0;
    i_reg_wr = 1; i_reg_addr = 4'd0; i_reg_wdata = 32'h7;
    tick();
    i_filter_busy = 0; tick();
    i_filter_busy = 1; tick();
    i_filter_busy = 0; tick();
    i_filter_busy = 0; tick();
    check_eq("pulse_pending_uaf", {28'd0, dut_uaf}, 32'h3);
    check_eq("pulse_pending_bsy", {31'd0, o_acfbsy}, 32'h1);
    tick();
    check_eq("pulse_applied_uaf", {28'd0, dut_uaf}, 32'h7);
    check_eq("pulse_applied_bsy", {31'd0, o_acfbsy}, 32'h0);
    do_req(0, 1, 4'd9, '0); check_eq("pulse_no_tmo", last_rdata, 32'h0);

    // Error paths
    do_req(0, 1, 4'd12, '0); check_eq("inv_err", {31'd0, last_err}, 32'h1); check_eq("inv_rdata", last_rdata, 32'h0);
    do_req(1, 1, 4'd4, 32'hDEADBEEF); check_eq("rdwr_err", {31'd0, last_err}, 32'h1);
    check_eq("rdwr_noupd", dut_afmr[3], 32'h0);

    // Reset in the middle of an enable change
    i_filter_busy = 1;
    do_req(1, 0, 4'd0, 32'h0);
    tick(); tick();
    apply_reset();
    check_eq("rst_mid_uaf", {28'd0, dut_uaf}, 32'h0);
    check_eq("rst_mid_bsy", {31'd0, o_acfbsy}, 32'h0);

    // Random traffic
    for (int it = 0; it < 500; it++) begin
      logic [3:0]  ra;
      logic [31:0] rd;
      int          op;
      i_filter_busy = ($urandom_range(0, 99) < 40);
      op = $urandom_range(0, 9);
      ra = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rd = $urandom;
      if (ra == 4'd0 && $urandom_range(0, 1) == 1) rd[3:0] = 4'h0;
      if (op < 4) begin
        tick();
      end else begin
        i_reg_wr = (op >= 7) || (op == 4 && $urandom_range(0, 3) == 0);
        i_reg_rd = (op < 7);
        i_reg_addr = ra; i_reg_wdata = rd;
        tick();
        i_filter_busy = ($urandom_range(0, 99) < 40);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
